// File: rtl/machine_ctrl_if.sv
// Signal bundle between the decoder/CSR file and the machine-mode trap sequencer.
// No valid/ready: the controller samples every input combinationally in each OPERATING cycle.
interface machine_ctrl_if;
  logic       illegal_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in;
  logic [4:0] rs2_addr_in;
  logic [4:0] rd_addr_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;

  logic       trap_taken_out;
  logic [1:0] pc_src_out;
  logic       flush_out;
  logic       instret_inc_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       misaligned_exception_out;

  modport master (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
    output mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  trap_taken_out, pc_src_out, flush_out, instret_inc_out, set_cause_out,
    input  set_epc_out, mie_clear_out, mie_set_out, i_or_e_out, cause_out,
    input  misaligned_exception_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
    input  mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output trap_taken_out, pc_src_out, flush_out, instret_inc_out, set_cause_out,
    output set_epc_out, mie_clear_out, mie_set_out, i_or_e_out, cause_out,
    output misaligned_exception_out
  );
endinterface

// File: rtl/machine_ctrl.sv
// Machine-mode trap/return sequencer: merges decoder exceptions, ECALL/EBREAK/MRET
// and enabled interrupts into PC-select, flush and CSR update strobes.
module machine_ctrl (
  input  logic           clk_in,
  input  logic           rst_in,
  machine_ctrl_if.slave  bus,
  output logic [1:0]     state_dbg_out
);

  localparam logic [1:0] ST_RESET       = 2'b00;
  localparam logic [1:0] ST_OPERATING   = 2'b01;
  localparam logic [1:0] ST_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] ST_TRAP_RETURN = 2'b11;

  logic [1:0] state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic       i_or_e_q, i_or_e_d;
  logic       mis_q, mis_d;

  logic is_system, is_ecall, is_ebreak, is_mret;
  logic irq_ext, irq_sw, irq_tmr, interrupt, exception, trap;
  logic [3:0] exc_code;

  assign is_system = (bus.opcode_6_to_2_in == 5'b11100) && (bus.funct3_in == 3'b000);
  assign is_ecall  = is_system && (bus.funct7_in == 7'd0) && (bus.rs2_addr_in == 5'd0) &&
                     (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
  assign is_ebreak = is_system && (bus.funct7_in == 7'd0) && (bus.rs2_addr_in == 5'd1) &&
                     (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
  assign is_mret   = is_system && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'd2) &&
                     (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);

  // Global MIE gates every source so the priority chain below sees only enabled interrupts.
  assign irq_ext   = bus.mie_in & bus.meie_in & bus.meip_in;
  assign irq_sw    = bus.mie_in & bus.msie_in & bus.msip_in;
  assign irq_tmr   = bus.mie_in & bus.mtie_in & bus.mtip_in;
  assign interrupt = irq_ext | irq_sw | irq_tmr;
  assign exception = bus.misaligned_instr_in | bus.illegal_instr_in | is_ecall | is_ebreak |
                     bus.misaligned_load_in | bus.misaligned_store_in;
  assign trap      = (state_q == ST_OPERATING) & (interrupt | exception);

  always_comb begin
    if (bus.misaligned_instr_in)      exc_code = 4'd0;
    else if (bus.illegal_instr_in)    exc_code = 4'd2;
    else if (is_ebreak)               exc_code = 4'd3;
    else if (bus.misaligned_load_in)  exc_code = 4'd4;
    else if (bus.misaligned_store_in) exc_code = 4'd6;
    else                              exc_code = 4'd11;
  end

  always_comb begin
    cause_d  = cause_q;
    i_or_e_d = i_or_e_q;
    mis_d    = mis_q;
    if (trap) begin
      i_or_e_d = interrupt;
      if (irq_ext)      cause_d = 4'd11;
      else if (irq_sw)  cause_d = 4'd3;
      else if (irq_tmr) cause_d = 4'd7;
      else              cause_d = exc_code;
      mis_d = ~interrupt & ((exc_code == 4'd0) | (exc_code == 4'd4) | (exc_code == 4'd6));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:       state_d = ST_OPERATING;
      ST_OPERATING: begin
        if (trap)         state_d = ST_TRAP_TAKEN;
        else if (is_mret) state_d = ST_TRAP_RETURN;
      end
      ST_TRAP_TAKEN:  state_d = ST_OPERATING;
      ST_TRAP_RETURN: state_d = ST_OPERATING;
      default:        state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_RESET;
      cause_q  <= 4'd0;
      i_or_e_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      i_or_e_q <= i_or_e_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    bus.pc_src_out    = 2'b00;
    bus.flush_out     = 1'b1;
    bus.set_cause_out = 1'b0;
    bus.set_epc_out   = 1'b0;
    bus.mie_clear_out = 1'b0;
    bus.mie_set_out   = 1'b0;
    case (state_q)
      ST_OPERATING: begin
        bus.pc_src_out = 2'b11;
        bus.flush_out  = 1'b0;
      end
      ST_TRAP_TAKEN: begin
        bus.pc_src_out    = 2'b10;
        bus.set_cause_out = 1'b1;
        bus.set_epc_out   = 1'b1;
        bus.mie_clear_out = 1'b1;
      end
      ST_TRAP_RETURN: begin
        bus.pc_src_out  = 2'b01;
        bus.mie_set_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap_taken_out           = trap;
  assign bus.instret_inc_out          = (state_q == ST_OPERATING) & ~trap & ~is_mret;
  assign bus.i_or_e_out               = i_or_e_q;
  assign bus.cause_out                = cause_q;
  assign bus.misaligned_exception_out = mis_q;
  assign state_dbg_out                = state_q;

endmodule

// File: tb/tb_machine_ctrl.sv
// Directed bench for machine_ctrl: a vector table run from OPERATING plus
// hand-written reset and reset-during-trap sequences.
module tb_machine_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_fail   = 0;

  machine_ctrl_if bus();

  machine_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .bus           (bus.slave),
    .state_dbg_out (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] OP_SYS = 5'b11100;
  localparam logic [4:0] OP_ALU = 5'b01100;
  localparam logic [6:0] F7_MRET = 7'b0011000;
  localparam logic [6:0] F7_WFI  = 7'b0001000;

  typedef struct {
    logic       ill, ml, ms, mi;
    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
    logic       exp_trap, exp_instret, exp_mret;
    logic [3:0] exp_cause;
    logic       exp_ioe, exp_mis;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  logic [3:0] last_cause;
  logic       last_ioe, last_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.illegal_instr_in    = 1'b0;
    bus.misaligned_load_in  = 1'b0;
    bus.misaligned_store_in = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    bus.opcode_6_to_2_in    = OP_ALU;
    bus.funct3_in           = 3'd0;
    bus.funct7_in           = 7'd0;
    bus.rs1_addr_in         = 5'd0;
    bus.rs2_addr_in         = 5'd0;
    bus.rd_addr_in          = 5'd0;
    bus.mie_in              = 1'b0;
    bus.meie_in             = 1'b0;
    bus.mtie_in             = 1'b0;
    bus.msie_in             = 1'b0;
    bus.meip_in             = 1'b0;
    bus.mtip_in             = 1'b0;
    bus.msip_in             = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.illegal_instr_in    = v.ill;
    bus.misaligned_load_in  = v.ml;
    bus.misaligned_store_in = v.ms;
    bus.misaligned_instr_in = v.mi;
    bus.opcode_6_to_2_in    = v.opc;
    bus.funct3_in           = v.f3;
    bus.funct7_in           = v.f7;
    bus.rs1_addr_in         = v.rs1;
    bus.rs2_addr_in         = v.rs2;
    bus.rd_addr_in          = v.rd;
    bus.mie_in              = v.mie;
    bus.meie_in             = v.meie;
    bus.mtie_in             = v.mtie;
    bus.msie_in             = v.msie;
    bus.meip_in             = v.meip;
    bus.mtip_in             = v.mtip;
    bus.msip_in             = v.msip;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] st);
    logic [1:0] exp_pc;
    logic       exp_flush;
    case (st)
      2'b00:   begin exp_pc = 2'b00; exp_flush = 1'b1; end
      2'b01:   begin exp_pc = 2'b11; exp_flush = 1'b0; end
      2'b10:   begin exp_pc = 2'b10; exp_flush = 1'b1; end
      default: begin exp_pc = 2'b01; exp_flush = 1'b1; end
    endcase
    chk({tag, " state"},     32'(state_dbg),         32'(st));
    chk({tag, " pc_src"},    32'(bus.pc_src_out),    32'(exp_pc));
    chk({tag, " flush"},     32'(bus.flush_out),     32'(exp_flush));
    chk({tag, " set_cause"}, 32'(bus.set_cause_out), 32'(st == 2'b10));
    chk({tag, " set_epc"},   32'(bus.set_epc_out),   32'(st == 2'b10));
    chk({tag, " mie_clear"}, 32'(bus.mie_clear_out), 32'(st == 2'b10));
    chk({tag, " mie_set"},   32'(bus.mie_set_out),   32'(st == 2'b11));
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] c, input logic ioe, input logic mis);
    chk({tag, " cause"},  32'(bus.cause_out),                32'(c));
    chk({tag, " i_or_e"}, 32'(bus.i_or_e_out),               32'(ioe));
    chk({tag, " mis"},    32'(bus.misaligned_exception_out), 32'(mis));
  endtask

  initial begin
    // ill ml ms mi | opc f3 f7 rs1 rs2 rd | mie meie mtie msie meip mtip msip | trap instret mret cause ioe mis
    tbl[0]  = '{1,0,0,0, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd2, 0,0};
    tbl[1]  = '{1,0,1,0, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd2, 0,0};
    tbl[2]  = '{0,0,1,0, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd6, 0,1};
    tbl[3]  = '{0,1,0,0, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd4, 0,1};
    tbl[4]  = '{0,0,0,1, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd0, 0,1};
    tbl[5]  = '{1,0,0,1, OP_ALU,0,0,0,0,1,       0,0,0,0,0,0,0, 1,0,0, 4'd0, 0,1};
    tbl[6]  = '{0,0,0,0, OP_SYS,0,0,0,1,0,       0,0,0,0,0,0,0, 1,0,0, 4'd3, 0,0};
    tbl[7]  = '{0,0,0,0, OP_SYS,0,0,0,0,0,       0,0,0,0,0,0,0, 1,0,0, 4'd11,0,0};
    tbl[8]  = '{0,1,0,0, OP_SYS,0,0,0,1,0,       0,0,0,0,0,0,0, 1,0,0, 4'd3, 0,0};
    tbl[9]  = '{1,0,0,0, OP_ALU,0,0,0,0,1,       1,1,1,0,1,1,0, 1,0,0, 4'd11,1,0};
    tbl[10] = '{0,0,0,0, OP_ALU,0,0,0,0,1,       0,1,1,0,1,1,0, 0,1,0, 4'd0, 0,0};
    tbl[11] = '{0,0,0,0, OP_ALU,0,0,0,0,1,       1,0,1,1,0,1,1, 1,0,0, 4'd3, 1,0};
    tbl[12] = '{0,0,0,0, OP_ALU,0,0,0,0,1,       1,0,1,0,0,1,0, 1,0,0, 4'd7, 1,0};
    tbl[13] = '{0,0,0,0, OP_ALU,0,0,0,0,1,       1,0,0,0,1,0,0, 0,1,0, 4'd0, 0,0};
    tbl[14] = '{0,0,0,0, OP_SYS,0,F7_MRET,0,2,0, 0,0,0,0,0,0,0, 0,0,1, 4'd0, 0,0};
    tbl[15] = '{1,0,0,0, OP_SYS,0,F7_MRET,0,2,0, 0,0,0,0,0,0,0, 1,0,0, 4'd2, 0,0};
    tbl[16] = '{0,0,0,0, OP_SYS,0,F7_WFI,0,5,0,  0,0,0,0,0,0,0, 0,1,0, 4'd0, 0,0};
    tbl[17] = '{0,0,0,0, OP_SYS,0,0,0,0,1,       0,0,0,0,0,0,0, 0,1,0, 4'd0, 0,0};
    tbl[18] = '{0,0,0,0, OP_SYS,0,F7_MRET,1,2,0, 0,0,0,0,0,0,0, 0,1,0, 4'd0, 0,0};
    tbl[19] = '{0,0,0,0, OP_SYS,1,0,0,0,0,       0,0,0,0,0,0,0, 0,1,0, 4'd0, 0,0};
    tbl[20] = '{0,0,1,0, OP_ALU,0,0,0,0,1,       1,0,0,0,0,1,0, 1,0,0, 4'd6, 0,1};

    // Reset held two cycles with a live exception on the inputs: nothing may trap.
    clear_inputs();
    bus.illegal_instr_in = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk_state("rst", 2'b00);
    chk_regs("rst", 4'd0, 1'b0, 1'b0);
    chk("rst trap_taken", 32'(bus.trap_taken_out), 32'd0);
    chk("rst instret", 32'(bus.instret_inc_out), 32'd0);
    clear_inputs();
    rst = 1'b0;
    step();
    chk_state("rst_rel", 2'b01);
    chk("rst_rel instret", 32'(bus.instret_inc_out), 32'd1);

    last_cause = 4'd0;
    last_ioe   = 1'b0;
    last_mis   = 1'b0;

    for (int i = 0; i < NV; i++) begin
      string tag;
      logic [1:0] nxt;
      tag = $sformatf("v%0d", i);
      apply(tbl[i]);
      #1;
      chk({tag, " trap_taken"}, 32'(bus.trap_taken_out), 32'(tbl[i].exp_trap));
      chk({tag, " instret"},    32'(bus.instret_inc_out), 32'(tbl[i].exp_instret));
      nxt = tbl[i].exp_trap ? 2'b10 : (tbl[i].exp_mret ? 2'b11 : 2'b01);
      step();
      // Inputs stay applied here so a held exception must not re-trap outside OPERATING.
      chk_state(tag, nxt);
      if (nxt != 2'b01) begin
        chk({tag, " held trap_taken"}, 32'(bus.trap_taken_out), 32'd0);
        chk({tag, " held instret"},    32'(bus.instret_inc_out), 32'd0);
      end
      if (tbl[i].exp_trap) begin
        last_cause = tbl[i].exp_cause;
        last_ioe   = tbl[i].exp_ioe;
        last_mis   = tbl[i].exp_mis;
      end
      chk_regs(tag, last_cause, last_ioe, last_mis);
      clear_inputs();
      if (nxt != 2'b01) begin
        step();
        chk_state({tag, " ret"}, 2'b01);
        chk_regs({tag, " ret"}, last_cause, last_ioe, last_mis);
      end
    end

    // ECALL trap, then reset asserted during TRAP_TAKEN.
    apply(tbl[7]);
    #1;
    chk("ecall trap_taken", 32'(bus.trap_taken_out), 32'd1);
    step();
    chk_state("ecall tt", 2'b10);
    chk_regs("ecall tt", 4'd11, 1'b0, 1'b0);
    clear_inputs();
    rst = 1'b1;
    step();
    chk_state("ecall rst", 2'b00);
    chk_regs("ecall rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_state("ecall rel", 2'b01);

    // Misaligned-store trap interrupted by reset must clear the latched mtval select.
    apply(tbl[2]);
    step();
    chk_state("ms tt", 2'b10);
    chk_regs("ms tt", 4'd6, 1'b0, 1'b1);
    clear_inputs();
    rst = 1'b1;
    step();
    chk_state("ms rst", 2'b00);
    chk_regs("ms rst", 4'd0, 1'b0, 1'b0);

    // Interrupt trap interrupted by reset must clear i_or_e.
    rst = 1'b0;
    step();
    apply(tbl[12]);
    step();
    chk_regs("tmr tt", 4'd7, 1'b1, 1'b0);
    clear_inputs();
    rst = 1'b1;
    step();
    chk_regs("tmr rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
